hazard_unit_mc: RTL

- Parametrised successor of the pipeline hazard unit.
- Computes register-match comparisons internally from raw register addresses, rather than taking precomputed Match_* inputs.
- Adds a third forwarding operand for multiply-accumulate (Ra).
- Adds a multi-cycle execute sequencer that holds an instruction in E for a variable latency while bubbling M.
- Adds a saturating stall-cycle performance counter.
- Sits beside controller/datapath in the pipelined core; drives all stall, flush and forward selects.

---
 rtl/hazard_unit_mc_if.sv | 36 +++
 rtl/hazard_unit_mc.sv | 127 ++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc_if.sv
// Signal bundle between the pipeline control path and the multi-cycle hazard unit.
interface hazard_unit_mc_if #(
    parameter int unsigned RA_WIDTH   = 4,
    parameter int unsigned LAT_WIDTH  = 4,
    parameter int unsigned PERF_WIDTH = 16
);
    logic [RA_WIDTH-1:0]   RA1D, RA2D;
    logic [RA_WIDTH-1:0]   RA1E, RA2E, RA3E;
    logic                  RA3ValidE;
    logic [RA_WIDTH-1:0]   WA3E, WA3M, WA3W;
    logic                  RegWriteM, RegWriteW, MemtoRegE;
    logic                  BranchTakenE, PCWrPendingF, PCSrcW;
    logic                  StartMcE;
    logic [LAT_WIDTH-1:0]  McLatE;
    logic [1:0]            ForwardAE, ForwardBE, ForwardCE;
    logic                  StallF, StallD, StallE;
    logic                  FlushD, FlushE, FlushM;
    logic                  McBusy;
    logic [PERF_WIDTH-1:0] StallCount;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, RA3E, RA3ValidE, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCWrPendingF,
               PCSrcW, StartMcE, McLatE,
        input  ForwardAE, ForwardBE, ForwardCE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, McBusy, StallCount
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, RA3E, RA3ValidE, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCWrPendingF,
               PCSrcW, StartMcE, McLatE,
        output ForwardAE, ForwardBE, ForwardCE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, McBusy, StallCount
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding, load-use stall, multi-cycle E sequencer
// and a saturating stall-cycle counter.
module hazard_unit_mc #(
    parameter int unsigned RA_WIDTH   = 4,
    parameter int unsigned LAT_WIDTH  = 4,
    parameter int unsigned PERF_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    hazard_unit_mc_if.slave  hz
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                state, state_next;
    logic [LAT_WIDTH-1:0]  cnt, cnt_next;
    logic [PERF_WIDTH-1:0] stall_count;
    logic                  lat_multi, mcstall, mc_busy, ldstall;
    logic [1:0]            fwd_a, fwd_b, fwd_c;
    logic                  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;

    // Register 15 is hard-wired and never forwarded; M has priority over W.
    function automatic logic [1:0] fwd_sel(input logic [RA_WIDTH-1:0] ra,
                                           input logic [RA_WIDTH-1:0] wa_m,
                                           input logic [RA_WIDTH-1:0] wa_w,
                                           input logic rw_m, input logic rw_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != '1) begin
            if (rw_m && (ra == wa_m))      sel = 2'b10;
            else if (rw_w && (ra == wa_w)) sel = 2'b01;
        end
        return sel;
    endfunction

    // Latency of 0 behaves as 1, so only 2 and up needs the sequencer.
    assign lat_multi = (hz.McLatE >= LAT_WIDTH'(2));

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Sequencer next state; StartMcE is ignored while the held op drains.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (hz.StartMcE && lat_multi) begin
                    state_next = BUSY;
                    cnt_next   = hz.McLatE - LAT_WIDTH'(1);
                end
            end
            BUSY: begin
                cnt_next = cnt - LAT_WIDTH'(1);
                if (cnt == LAT_WIDTH'(1)) state_next = IDLE;
            end
        endcase
    end

    // Sequencer outputs.
    always_comb begin
        mcstall = 1'b0;
        mc_busy = 1'b0;
        case (state)
            IDLE: mcstall = hz.StartMcE && lat_multi;
            BUSY: begin
                mcstall = (cnt >= LAT_WIDTH'(2));
                mc_busy = 1'b1;
            end
        endcase
    end

    assign ldstall = hz.MemtoRegE && ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));

    // Stall/flush/forward; while reset is low the pipe is flushed and nothing stalls.
    always_comb begin
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        fwd_c   = 2'b00;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_m = 1'b1;
        if (reset) begin
            fwd_a   = fwd_sel(hz.RA1E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW);
            fwd_b   = fwd_sel(hz.RA2E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW);
            if (hz.RA3ValidE)
                fwd_c = fwd_sel(hz.RA3E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW);
            stall_e = mcstall;
            flush_m = mcstall;
            stall_d = ldstall | mcstall;
            stall_f = ldstall | mcstall | hz.PCWrPendingF;
            // A held E instruction must never be killed.
            flush_e = (ldstall | hz.BranchTakenE) & ~mcstall;
            flush_d = (hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE) & ~mcstall;
        end
    end

    // Saturating count of front-end stall cycles.
    always_ff @(posedge clk) begin
        if (!reset)
            stall_count <= '0;
        else if (stall_f && (stall_count != '1))
            stall_count <= stall_count + PERF_WIDTH'(1);
    end

    assign hz.ForwardAE  = fwd_a;
    assign hz.ForwardBE  = fwd_b;
    assign hz.ForwardCE  = fwd_c;
    assign hz.StallF     = stall_f;
    assign hz.StallD     = stall_d;
    assign hz.StallE     = stall_e;
    assign hz.FlushD     = flush_d;
    assign hz.FlushE     = flush_e;
    assign hz.FlushM     = flush_m;
    assign hz.McBusy     = reset & mc_busy;
    assign hz.StallCount = stall_count;
endmodule
